key_debounce_array: RTL and testbench

Parametrised multi-channel key conditioner for the calendar/clock front panel. Each channel synchronises one raw mechanical key, debounces it over a programmable window, and produces a clean level plus one-cycle press, release and long-press events. An optional auto-repeat stream supports held "add"-style keys. It sits between the board key pins and the mode/adjust control logic, and replaces per-key single-channel debounce instances.

---
 rtl/key_pkg.sv | 7 +
 rtl/key_debounce_chan.sv | 83 ++++++++
 rtl/key_debounce_array.sv | 37 +++
 tb/tb_key_debounce_array.sv | 130 +++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared FSM state type and 50 MHz default timing constants for the key conditioner
package key_pkg;
    typedef enum logic [1:0] {KEY_IDLE, KEY_PRESSED, KEY_HELD} key_state_t;
    localparam int WIPE_50M   = 1_000_000;
    localparam int LONG_50M   = 50_000_000;
    localparam int REPEAT_50M = 10_000_000;
endpackage

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: one key channel (sync, debounce, press/long FSM); auto-repeat built only with KEY_REPEAT_EN
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int WIPE_TIME   = WIPE_50M,
    parameter int LONG_TIME   = LONG_50M,
    parameter int REPEAT_TIME = REPEAT_50M,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);
    localparam int DW = $clog2(WIPE_TIME);
    localparam int HW = $clog2(LONG_TIME);
    localparam logic IDLE_PIN = (ACTIVE_LOW != 0);
    logic s1, s2, sample, flip, go_long;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    key_state_t state;
    assign sample  = s2 ^ IDLE_PIN;
    assign flip    = (sample != key_level) && (db_cnt == DW'(WIPE_TIME - 1));
    assign go_long = (state == KEY_PRESSED) && !flip && (hold_cnt == HW'(LONG_TIME - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            s1            <= IDLE_PIN;
            s2            <= IDLE_PIN;
            db_cnt        <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            hold_cnt      <= '0;
            state         <= KEY_IDLE;
        end else begin
            s1            <= key_in;
            s2            <= s1;
            db_cnt        <= (sample == key_level || flip) ? '0 : db_cnt + 1'b1;
            key_level     <= flip ? sample : key_level;
            press_pulse   <= flip && sample;
            release_pulse <= flip && !sample;
            long_pulse    <= go_long;
            case (state)
                KEY_IDLE: begin
                    if (flip && sample) begin
                        state    <= KEY_PRESSED;
                        hold_cnt <= '0;
                    end
                end
                KEY_PRESSED: begin
                    if (flip) state <= KEY_IDLE;
                    else if (go_long) state <= KEY_HELD;
                    else hold_cnt <= hold_cnt + 1'b1;
                end
                KEY_HELD: if (flip) state <= KEY_IDLE;
                default: state <= KEY_IDLE;
            endcase
        end
    end
`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TIME);
    logic [RW-1:0] rpt_cnt;
    logic rpt_hit;
    assign rpt_hit = rpt_cnt == RW'(REPEAT_TIME - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= (state == KEY_HELD) && !flip && rpt_hit;
            if (go_long) rpt_cnt <= '0;
            else if (state == KEY_HELD && !flip) rpt_cnt <= rpt_hit ? '0 : rpt_cnt + 1'b1;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif
endmodule

// File: rtl/key_debounce_array.sv
// key_debounce_array: CH independent key conditioner channels; auto-repeat enabled by KEY_REPEAT_EN
module key_debounce_array
    import key_pkg::*;
#(
    parameter int CH          = 4,
    parameter int WIPE_TIME   = WIPE_50M,
    parameter int LONG_TIME   = LONG_50M,
    parameter int REPEAT_TIME = REPEAT_50M,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] key_in,
    output logic [CH-1:0] key_level,
    output logic [CH-1:0] press_pulse,
    output logic [CH-1:0] release_pulse,
    output logic [CH-1:0] long_pulse,
    output logic [CH-1:0] repeat_pulse
);
    for (genvar c = 0; c < CH; c++) begin : g_chan
        key_debounce_chan #(
            .WIPE_TIME(WIPE_TIME),
            .LONG_TIME(LONG_TIME),
            .REPEAT_TIME(REPEAT_TIME),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_chan (
            .clk(clk),
            .rst(rst),
            .key_in(key_in[c]),
            .key_level(key_level[c]),
            .press_pulse(press_pulse[c]),
            .release_pulse(release_pulse[c]),
            .long_pulse(long_pulse[c]),
            .repeat_pulse(repeat_pulse[c])
        );
    end
endmodule

// File: tb/tb_key_debounce_array.sv
// tb_key_debounce_array: directed stimulus with a time-stamped expectation queue checked on the falling edge
module tb_key_debounce_array;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] key_in = 4'hF;
    logic [3:0] key_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
`ifdef KEY_REPEAT_EN
    localparam logic [3:0] RPT2 = 4'h4;
`else
    localparam logic [3:0] RPT2 = 4'h0;
`endif
    typedef struct {
        int          at;
        string       tag;
        logic [19:0] mask;
        logic [19:0] val;
    } chk_t;
    chk_t q[$];
    int cyc = 0;
    int checks = 0;
    int passed = 0;

    key_debounce_array #(
        .CH(4), .WIPE_TIME(8), .LONG_TIME(32), .REPEAT_TIME(16), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] f(input logic [3:0] lvl, prs, rel, lng, rpt);
        return {rpt, lng, rel, prs, lvl};
    endfunction

    task automatic exp(input int dt, input string tag, input logic [19:0] m, input logic [19:0] v);
        q.push_back('{cyc + dt, tag, m, v});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [19:0] o;
        o = {repeat_pulse, long_pulse, release_pulse, press_pulse, key_level};
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at == cyc) begin
                checks++;
                assert ((o & q[i].mask) === q[i].val) passed++;
                else begin
                    $display("FAIL %s cyc=%0d observed=%h expected=%h", q[i].tag, cyc, o & q[i].mask, q[i].val);
                    $error("%s observed %h expected %h", q[i].tag, o & q[i].mask, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        tick(2);
        rst = 1'b0;
        for (int d = 0; d < 20; d++) exp(d, "reset_quiet", 20'hFFFFF, 20'h0);
        tick(20);
        key_in[0] = 1'b0;
        exp(9,  "ch0_pre",   f(1, 1, 0, 0, 0), 20'h0);
        exp(10, "ch0_press", f(1, 1, 0, 0, 0), f(1, 1, 0, 0, 0));
        exp(11, "ch0_width", f(1, 1, 0, 0, 0), f(1, 0, 0, 0, 0));
        tick(15);
        rst = 1'b1;
        exp(1, "rst_clear", 20'hFFFFF, 20'h0);
        tick(1);
        rst = 1'b0;
        exp(9,  "ch0_rearm_pre", f(1, 1, 0, 0, 0), 20'h0);
        exp(10, "ch0_rearm",     f(1, 1, 0, 0, 0), f(1, 1, 0, 0, 0));
        tick(12);
        key_in[0] = 1'b1;
        exp(9,  "ch0_rel_pre", f(1, 0, 1, 0, 0), f(1, 0, 0, 0, 0));
        exp(10, "ch0_release", f(1, 1, 1, 1, 1), f(0, 0, 1, 0, 0));
        tick(15);
        for (int d = 0; d < 57; d++) exp(d, "ch1_quiet", f(2, 2, 2, 2, 2), 20'h0);
        for (int g = 1; g <= 7; g++) begin
            key_in[1] = 1'b0;
            tick(g);
            key_in[1] = 1'b1;
            tick(2);
        end
        tick(15);
        key_in[2] = 1'b0;
        exp(10, "ch2_press",      f(4, 4, 4, 4, 4), f(4, 4, 0, 0, 0));
        exp(41, "ch2_prelong",    f(4, 4, 4, 4, 4), f(4, 0, 0, 0, 0));
        exp(42, "ch2_long",       f(4, 4, 4, 4, 4), f(4, 0, 0, 4, 0));
        exp(43, "ch2_long_width", f(4, 4, 4, 4, 4), f(4, 0, 0, 0, 0));
        exp(57, "ch2_rpt1_pre",   f(4, 4, 4, 4, 4), f(4, 0, 0, 0, 0));
        exp(58, "ch2_rpt1",       f(4, 4, 4, 4, 4), f(4, 0, 0, 0, RPT2));
        exp(74, "ch2_rpt2",       f(4, 4, 4, 4, 4), f(4, 0, 0, 0, RPT2));
        exp(75, "ch2_rpt_width",  f(4, 4, 4, 4, 4), f(4, 0, 0, 0, 0));
        exp(80, "ch2_release",    f(4, 4, 4, 4, 4), f(0, 0, 4, 0, 0));
        exp(90, "ch2_idle",       f(4, 4, 4, 4, 4), 20'h0);
        tick(70);
        key_in[2] = 1'b1;
        tick(30);
        key_in[3] = 1'b0;
        for (int d = 0; d < 46; d++) exp(d, "ch3_nolong", f(0, 0, 0, 8, 0), 20'h0);
        exp(10, "ch3_press",   f(8, 8, 8, 0, 0), f(8, 8, 0, 0, 0));
        exp(30, "ch3_release", f(8, 8, 8, 0, 0), f(0, 0, 8, 0, 0));
        tick(20);
        key_in[3] = 1'b1;
        tick(30);
        key_in = 4'h0;
        exp(9,  "all_pre",   f(0, 15, 0, 0, 0), 20'h0);
        exp(10, "all_press", f(15, 15, 0, 0, 0), f(15, 15, 0, 0, 0));
        exp(11, "all_width", f(0, 15, 0, 0, 0), 20'h0);
        tick(15);
        key_in = 4'hF;
        exp(10, "all_release", f(15, 15, 15, 15, 0), f(0, 0, 15, 0, 0));
        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        checks++;
        assert (q.size() === 0) passed++;
        else begin
            $display("FAIL drain pending=%0d required=0", q.size());
            $error("drain pending %0d", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
